// File: rtl/md_defs.sv
// Shared multiply/divide definitions: op encodings, default latencies, FSM states.
package md_defs;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational {HI, LO} result for mult/multu/div/divu.
module md_calc
    import md_defs::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o
);

    logic [63:0] prod_s, prod_u;
    logic        sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, q, r;

    // Signed divide works on magnitudes; quotient/remainder signs are fixed up after.
    always_comb begin
        prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
        prod_u = {32'd0, a_i} * {32'd0, b_i};
        sgn    = (op_i == MD_DIV);
        a_neg  = sgn & a_i[31];
        b_neg  = sgn & b_i[31];
        a_mag  = a_neg ? -a_i : a_i;
        b_mag  = b_neg ? -b_i : b_i;
        // keep the divider defined when the divisor is zero; that case is overridden below
        b_safe = (b_i == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r      = a_neg ? -r_mag : r_mag;

        res_o = 64'd0;
        case (op_i)
            MD_MULT:  res_o = prod_s;
            MD_MULTU: res_o = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b_i == 32'd0)
                    res_o = {a_i, 32'hFFFF_FFFF};
                else if (sgn && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF)
                    res_o = {32'd0, 32'h8000_0000};
                else
                    res_o = {r, q};
            end
            default:  res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency result commit.
module md_unit
    import md_defs::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        e_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] Src1,
    input  logic [31:0] Src2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] calc_res;

    md_calc u_calc (
        .op_i  (md_op),
        .a_i   (Src1),
        .b_i   (Src2),
        .res_o (calc_res)
    );

    // Next state: accept in IDLE (busy low), count down in RUN, commit on the 1->0 step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (e_valid) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            cnt_d   = CW'(MULT_CYCLES);
                            pend_d  = calc_res;
                            state_d = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            cnt_d   = CW'(DIV_CYCLES);
                            pend_d  = calc_res;
                            state_d = MD_RUN;
                        end
                        MD_MTHI: hi_d = Src1;
                        MD_MTLO: lo_d = Src1;
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                // anything presented while running is dropped
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = MD_IDLE;
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // State registers; synchronous reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // mfhi/mflo read path straight from the architectural registers.
    always_comb begin
        md_out = 32'd0;
        case (md_op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the E stage of the 5-stage MIPS32 pipeline. It consumes the forwarded E-stage operands `Src1`/`Src2` (rs/rt) and executes mult, multu, div, divu, mthi and mtlo against internal HI/LO registers. It also supplies mfhi/mflo data to the E-stage result mux. A `busy` output lets the hazard unit stall any D-stage multiply/divide-class instruction while an operation is in flight.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: cycles from accepted mult/multu to HI/LO commit.
- `DIV_CYCLES`, default 10: cycles from accepted div/divu to HI/LO commit.

Ports:
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `reset_n` input, 1: synchronous, active-low reset. Sampled on `clk`.
- `e_valid` input, 1: E-stage instruction is real, not a bubble.
- `md_op` input, 4: decoded op (`MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MFHI`, `MD_MFLO`, `MD_MTHI`, `MD_MTLO`).
- `Src1` input, 32: forwarded rs value.
- `Src2` input, 32: forwarded rt value.
- `busy` output, 1: operation in flight.
- `hi` output, 32: HI register.
- `lo` output, 32: LO register.
- `md_out` output, 32: combinational. `hi` for `MD_MFHI`, `lo` for `MD_MFLO`, else 0.

## Operation

- Accept condition: `e_valid && !busy && reset_n`.
- Accepted mult/multu/div/divu:
  - Result is computed from `Src1`/`Src2` at the accept edge and held in pending registers.
  - Counter is loaded with `MULT_CYCLES` or `DIV_CYCLES`.
- mult: signed 64-bit product; HI = upper 32 bits, LO = lower 32 bits.
- multu: unsigned 64-bit product; same split.
- div/divu:
  - LO = quotient truncated toward zero, HI = remainder.
  - Signed remainder takes the sign of the dividend.
  - Divide by zero: LO = 0xFFFFFFFF, HI = `Src1`, for both signed and unsigned.
  - Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- Accepted mthi/mtlo write `Src1` into HI/LO at the accept edge. The counter is not loaded; `busy` stays 0.
- Ops arriving while `busy` = 1 are ignored, and HI/LO are not disturbed. The hazard unit must prevent this case; the bench flags it with an assertion.
- States:
  - IDLE (counter = 0) → RUN on accepted mult/div.
  - RUN: counter decrements each cycle.
  - RUN → IDLE when the counter goes 1 → 0. Pending HI/LO commit on that same edge.
- `busy` = (counter != 0). It is registered, so there is no combinational path from inputs to `busy`.

## Timing

- Reset (`reset_n` = 0 at an edge): `hi` = 0, `lo` = 0, `busy` = 0, counter = 0, pending = 0.
- Reset mid-operation aborts the operation. The pending result is discarded and never committed.
- Accept at edge T:
  - `busy` = 1 during cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
  - HI/LO update at edge T+N.
  - `busy` = 0 and the new `hi`/`lo` are visible in the cycle after edge T+N.
- A new op may be accepted at edge T+N+1. No back-to-back overlap is allowed.
- mthi/mtlo at edge T: new value visible in cycle T+1. This is 1-cycle latency.
- `md_out` has zero latency from `md_op` and reflects the current `hi`/`lo` register contents. mfhi while `busy` is prevented by the hazard unit.
- Parameters must be ≥ 1. N = 1 gives `busy` for exactly one cycle.

## Structure

- Shared package `md_defs`:
  - `md_op` encodings (4-bit localparams).
  - Default `MULT_CYCLES` and `DIV_CYCLES`.
  - Shared by the decoder, the hazard unit and this block.
- Sub-module `md_calc`: purely combinational. Produces the 64-bit {HI, LO} result from op, `Src1` and `Src2`, including the divide-by-zero and signed-overflow cases.
- `md_unit` itself holds the counter, pending registers, HI/LO, and the accept/commit control.

## Test plan

- mult −3 × 5 (0xFFFFFFFD, 0x00000005):
  - `busy` is high for exactly 5 cycles.
  - Then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- multu 0xFFFFFFFF × 2 → HI = 0x00000001, LO = 0xFFFFFFFE.
- Division results:
  - div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 10 busy cycles.
  - divu 7 / 0 → LO = 0xFFFFFFFF, HI = 0x00000007.
- mthi 0x12345678, then mfhi the next cycle → `md_out` = 0x12345678, `busy` never asserts.
- Ignored-op and bubble handling:
  - Start div; a mult arrives while `busy` → the mult is ignored and only the div result commits.
  - Any op with `e_valid` = 0 → no effect.
- Reset mid-operation:
  - Start mult 3 × 4, then pulse `reset_n` low during cycle 3 of `busy`.
  - Result: `busy` = 0, HI = LO = 0 afterwards, and no late commit of 12.
